// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master.
//   spi_state_t : transaction sequencer states
//   spi_mode_t  : per-transaction mode, captured when a word is accepted
//   cs_width()  : width of the chip-select index for a given number of selects
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD,
      GAP
   } spi_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
      logic lsb_first;
   } spi_mode_t;

   function automatic int cs_width(input int num_cs);
      return (num_cs <= 1) ? 1 : $clog2(num_cs);
   endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Front-end / pin bundle of the SPI master.
//   Request side : tx_valid, tx_ready, tx_data, cs_sel, cpol, cpha, lsb_first
//   Receive side : rx_valid, rx_data
//   Status       : busy
//   SPI pins     : sclk, mosi, miso, cs_n
// modport master is the SPI master's own view; modport slave is the view of
// whatever drives requests and the SPI pins from the other side.
interface spi_master_param_if
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 1
);
   localparam int CS_W = cs_width(NUM_CS);

   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;
   logic [CS_W-1:0]   cs_sel;
   logic              cpol;
   logic              cpha;
   logic              lsb_first;
   logic              rx_valid;
   logic [DATA_W-1:0] rx_data;
   logic              busy;
   logic              sclk;
   logic              mosi;
   logic              miso;
   logic [NUM_CS-1:0] cs_n;

   modport master (
      input  tx_valid, tx_data, cs_sel, cpol, cpha, lsb_first, miso,
      output tx_ready, rx_valid, rx_data, busy, sclk, mosi, cs_n
   );

   modport slave (
      output tx_valid, tx_data, cs_sel, cpol, cpha, lsb_first, miso,
      input  tx_ready, rx_valid, rx_data, busy, sclk, mosi, cs_n
   );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master.
//   clk, rst       : system clock, synchronous active-high reset
//   en_i           : high in every non-IDLE state; low holds the timer preloaded
//   xfer_i         : sequencer is in XFER
//   lead_half_i    : current XFER half-period is a leading (even) one
//   phase_done_o   : last clk cycle of the current CLK_DIV-cycle phase
//   lead_edge_o    : first cycle of a leading half-period (sclk just left idle level)
//   trail_edge_o   : first cycle of a trailing half-period (sclk just returned to idle)
module spi_clk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic xfer_i,
   input  logic lead_half_i,
   output logic phase_done_o,
   output logic lead_edge_o,
   output logic trail_edge_o
);

   localparam int HP_W = $clog2(CLK_DIV + 1);
   localparam logic [HP_W-1:0] RELOAD = HP_W'(CLK_DIV - 1);

   logic [HP_W-1:0] hp_cnt_q;
   logic [HP_W-1:0] hp_cnt_d;
   logic            phase_first;

   // Down-counter: holds RELOAD while disabled so the first enabled cycle is
   // the first cycle of a phase; terminal count 0 marks the phase end.
   always_comb begin
      hp_cnt_d = hp_cnt_q;
      if (!en_i || (hp_cnt_q == '0)) begin
         hp_cnt_d = RELOAD;
      end else begin
         hp_cnt_d = hp_cnt_q - HP_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hp_cnt_q <= RELOAD;
      end else begin
         hp_cnt_q <= hp_cnt_d;
      end
   end

   assign phase_first  = en_i && xfer_i && (hp_cnt_q == RELOAD);
   assign phase_done_o = en_i && (hp_cnt_q == '0);
   assign lead_edge_o  = phase_first && lead_half_i;
   assign trail_edge_o = phase_first && !lead_half_i;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_master_param_if.master -- valid/ready request with per-word
//              mode and chip-select, rx_valid/rx_data result, busy, SPI pins.
// All SPI pins (sclk, mosi, cs_n) come straight from flops.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a word; sclk tracks the cpol input, cs_n all high
// SETUP | CLK_DIV cycles with the selected cs_n low before the first edge
// XFER  | 2*DATA_W half-periods of CLK_DIV cycles; shifting both ways
// HOLD  | CLK_DIV cycles with cs_n still low after the last edge, mosi 0
// GAP   | CLK_DIV cycles with cs_n high; rx_valid on its first cycle
module spi_master_param
   import spi_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 2,
   parameter int NUM_CS  = 1
) (
   input  logic                clk,
   input  logic                rst,
   spi_master_param_if.master  bus
);

   localparam int CS_W  = cs_width(NUM_CS);
   localparam int BIT_W = $clog2(2 * DATA_W + 1);
   localparam logic [BIT_W-1:0] LAST_HALF = BIT_W'(2 * DATA_W - 1);

   spi_state_t        state_q, state_d;
   spi_mode_t         mode_q, mode_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic [BIT_W-1:0]  hp_left_q, hp_left_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              rx_valid_q, rx_valid_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d;

   logic              accept;
   logic              phase_done;
   logic              lead_edge;
   logic              trail_edge;
   logic              sample_now;
   logic              advance_now;

   function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] v,
                                                   input logic lsb);
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk          (clk),
      .rst          (rst),
      .en_i         (state_q != IDLE),
      .xfer_i       (state_q == XFER),
      // hp_left counts down from 2*DATA_W-1, so an odd remainder is an even
      // (leading) half-period index.
      .lead_half_i  (hp_left_q[0]),
      .phase_done_o (phase_done),
      .lead_edge_o  (lead_edge),
      .trail_edge_o (trail_edge)
   );

   assign accept     = (state_q == IDLE) && bus.tx_valid;
   assign sample_now = mode_q.cpha ? trail_edge : lead_edge;

   // mosi moves together with the sclk toggle that starts the next half-period:
   // CPHA=1 on every leading edge, CPHA=0 on every trailing edge but the last
   // (the first CPHA=0 bit is already on the line from SETUP).
   always_comb begin
      advance_now = 1'b0;
      if (state_q == SETUP) begin
         advance_now = mode_q.cpha;
      end else if (state_q == XFER && hp_left_q != '0) begin
         advance_now = mode_q.cpha ? !hp_left_q[0]
                                   : (hp_left_q[0] && (hp_left_q != BIT_W'(1)));
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      hp_left_d  = hp_left_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      rx_valid_d = 1'b0;
      cs_n_d     = cs_n_q;

      if (sample_now) begin
         rx_sh_d = mode_q.lsb_first ? {bus.miso, rx_sh_q[DATA_W-1:1]}
                                    : {rx_sh_q[DATA_W-2:0], bus.miso};
      end

      if (phase_done && advance_now) begin
         mosi_d  = head_bit(tx_sh_q, mode_q.lsb_first);
         tx_sh_d = drop_head(tx_sh_q, mode_q.lsb_first);
      end

      unique case (state_q)
         IDLE: begin
            sclk_d = bus.cpol;
            mosi_d = 1'b0;
            cs_n_d = '1;
            if (accept) begin
               state_d          = SETUP;
               mode_d.cpol      = bus.cpol;
               mode_d.cpha      = bus.cpha;
               mode_d.lsb_first = bus.lsb_first;
               rx_sh_d          = '0;
               // Out-of-range cs_sel matches no line, so every cs_n stays high.
               for (int i = 0; i < NUM_CS; i++) begin
                  cs_n_d[i] = !(bus.cs_sel == CS_W'(i));
               end
               if (bus.cpha) begin
                  tx_sh_d = bus.tx_data;
               end else begin
                  mosi_d  = head_bit(bus.tx_data, bus.lsb_first);
                  tx_sh_d = drop_head(bus.tx_data, bus.lsb_first);
               end
            end
         end
         SETUP: begin
            if (phase_done) begin
               state_d   = XFER;
               hp_left_d = LAST_HALF;
               sclk_d    = !sclk_q;
            end
         end
         XFER: begin
            if (phase_done) begin
               if (hp_left_q == '0) begin
                  state_d = HOLD;
                  sclk_d  = mode_q.cpol;
                  mosi_d  = 1'b0;
               end else begin
                  hp_left_d = hp_left_q - BIT_W'(1);
                  sclk_d    = !sclk_q;
               end
            end
         end
         HOLD: begin
            if (phase_done) begin
               state_d    = GAP;
               cs_n_d     = '1;
               rx_valid_d = 1'b1;
               rx_data_d  = rx_sh_q;
            end
         end
         GAP: begin
            if (phase_done) begin
               state_d = IDLE;
               sclk_d  = bus.cpol;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         hp_left_q  <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         cs_n_q     <= '1;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         hp_left_q  <= hp_left_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         rx_valid_q <= rx_valid_d;
         cs_n_q     <= cs_n_d;
      end
   end

   assign bus.tx_ready = (state_q == IDLE) && !rst;
   assign bus.busy     = (state_q != IDLE);
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.sclk     = sclk_q;
   assign bus.mosi     = mosi_q;
   assign bus.cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: two instances share the stimulus.
//   A: DATA_W=8,  CLK_DIV=2, NUM_CS=4
//   B: DATA_W=16, CLK_DIV=1, NUM_CS=3 (cs_sel=3 is the out-of-range select;
//      a 2-bit cs_sel cannot hold 5)
// Expected values come from the bit-order rules and the timeline arithmetic
// (rx_valid at 1+D*(2W+2), ready at 1+D*(2W+3) after accept).
module tb_spi_master_param;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        tv      = 1'b0;
   logic [15:0] td      = '0;
   logic [1:0]  cs      = '0;
   logic        cpol_v  = 1'b0;
   logic        cpha_v  = 1'b0;
   logic        lsb_v   = 1'b0;
   logic        sel     = 1'b0;
   logic        loop_en = 1'b1;
   logic        miso_c  = 1'b0;
   int          cyc     = 0;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_master_param_if #(.DATA_W(8),  .NUM_CS(4)) bus_a ();
   spi_master_param_if #(.DATA_W(16), .NUM_CS(3)) bus_b ();

   assign bus_a.tx_valid  = tv && !sel;
   assign bus_a.tx_data   = td[7:0];
   assign bus_a.cs_sel    = cs;
   assign bus_a.cpol      = cpol_v;
   assign bus_a.cpha      = cpha_v;
   assign bus_a.lsb_first = lsb_v;
   assign bus_a.miso      = loop_en ? bus_a.mosi : miso_c;

   assign bus_b.tx_valid  = tv && sel;
   assign bus_b.tx_data   = td;
   assign bus_b.cs_sel    = cs;
   assign bus_b.cpol      = cpol_v;
   assign bus_b.cpha      = cpha_v;
   assign bus_b.lsb_first = lsb_v;
   assign bus_b.miso      = loop_en ? bus_b.mosi : miso_c;

   spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.master)
   );

   spi_master_param #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(3)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.master)
   );

   logic        o_ready, o_rxv, o_busy, o_sclk, o_mosi;
   logic [15:0] o_rxd;
   logic [3:0]  o_csn;

   always_comb begin
      o_ready = bus_a.tx_ready;
      o_rxv   = bus_a.rx_valid;
      o_busy  = bus_a.busy;
      o_sclk  = bus_a.sclk;
      o_mosi  = bus_a.mosi;
      o_rxd   = {8'h00, bus_a.rx_data};
      o_csn   = bus_a.cs_n;
      if (sel) begin
         o_ready = bus_b.tx_ready;
         o_rxv   = bus_b.rx_valid;
         o_busy  = bus_b.busy;
         o_sclk  = bus_b.sclk;
         o_mosi  = bus_b.mosi;
         o_rxd   = bus_b.rx_data;
         o_csn   = {1'b1, bus_b.cs_n};
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // One transaction from IDLE; entered and left at a negedge.
   task automatic do_xfer(input logic dsel, input logic [15:0] data,
                          input logic p_cpol, input logic p_cpha, input logic p_lsb,
                          input logic [1:0] p_cs, input logic p_loop, input logic p_miso,
                          input logic keep_valid, input int abort_at,
                          output int t_acc, output int t_rxv);
      int          w, d, ncs, n_end, wait_n;
      int          rxv_cnt, rxv_off, rdy_off, lead_n, trail_n, cs_bad;
      logic [15:0] exp_bits, mosi_bits, exp_rx, mask, rx_got;
      logic [3:0]  pat, exp_cs;
      logic        sclk_prev, sclk_first, sclk_last, mosi_setup, mosi_hold;

      w     = dsel ? 16 : 8;
      d     = dsel ? 1 : 2;
      ncs   = dsel ? 3 : 4;
      n_end = 1 + d * (2 * w + 3);
      mask  = dsel ? 16'hFFFF : 16'h00FF;
      exp_bits = '0;
      for (int i = 0; i < w; i++) exp_bits[i] = data[p_lsb ? i : (w - 1 - i)];
      exp_rx = p_loop ? (data & mask) : (p_miso ? mask : 16'h0000);
      for (int j = 0; j < 4; j++) pat[j] = !((j == int'(p_cs)) && (j < ncs));

      sel = dsel; loop_en = p_loop; miso_c = p_miso;
      cpol_v = p_cpol; cpha_v = p_cpha; lsb_v = p_lsb; cs = p_cs; td = data;
      #1;
      wait_n = 0;
      while (o_ready !== 1'b1 && wait_n < 200) begin
         @(negedge clk);
         wait_n++;
      end
      check("ready_wait", {31'd0, o_ready}, 32'd1);
      tv    = 1'b1;
      t_acc = cyc;
      t_rxv = -1;

      rxv_cnt = 0; rxv_off = -1; rdy_off = -1; lead_n = 0; trail_n = 0; cs_bad = 0;
      mosi_bits = '0; rx_got = '0; sclk_prev = p_cpol;
      sclk_first = 1'bx; sclk_last = 1'bx; mosi_setup = 1'bx; mosi_hold = 1'bx;
      for (int n = 1; n <= n_end; n++) begin
         @(negedge clk);
         if (n == 1 && !keep_valid) tv = 1'b0;
         if (o_rxv === 1'b1) begin
            rxv_cnt++;
            rxv_off = n;
            t_rxv   = cyc;
            rx_got  = o_rxd;
         end
         if (o_ready === 1'b1 && rdy_off < 0) rdy_off = n;
         if (n == 1) begin
            sclk_first = o_sclk;
            mosi_setup = o_mosi;
         end
         if (n == d * (2 * w + 1)) sclk_last = o_sclk;
         if (n == 1 + d * (2 * w + 1)) mosi_hold = o_mosi;
         exp_cs = (n <= d * (2 * w + 2)) ? pat : 4'hF;
         if (o_csn !== exp_cs) cs_bad++;
         if (o_sclk !== sclk_prev) begin
            if (o_sclk === ~p_cpol) begin
               if (lead_n < 16) mosi_bits[lead_n] = o_mosi;
               lead_n++;
            end else begin
               trail_n++;
            end
         end
         sclk_prev = o_sclk;
         if (n == abort_at) break;
      end

      if (abort_at > 0) begin
         rst = 1'b1;
         @(negedge clk);
         check("abort_cs_n",  {28'd0, o_csn},   32'hF);
         check("abort_sclk",  {31'd0, o_sclk},  32'd0);
         check("abort_mosi",  {31'd0, o_mosi},  32'd0);
         check("abort_busy",  {31'd0, o_busy},  32'd0);
         check("abort_ready", {31'd0, o_ready}, 32'd0);
         rst = 1'b0;
         tv  = 1'b0;
         for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (o_rxv === 1'b1) rxv_cnt++;
         end
         check("abort_no_rxv", rxv_cnt, 32'd0);
      end else begin
         check("rxv_count",   rxv_cnt, 32'd1);
         check("rxv_time",    rxv_off, 1 + d * (2 * w + 2));
         check("rx_data",     {16'd0, rx_got}, {16'd0, exp_rx});
         check("ready_time",  rdy_off, n_end);
         check("lead_edges",  lead_n,  w);
         check("trail_edges", trail_n, w);
         check("mosi_bits",   {16'd0, mosi_bits}, {16'd0, exp_bits});
         check("cs_n_window", cs_bad,  32'd0);
         check("sclk_setup",  {31'd0, sclk_first}, {31'd0, p_cpol});
         check("sclk_xfer_end", {31'd0, sclk_last}, {31'd0, p_cpol});
         check("mosi_setup",  {31'd0, mosi_setup}, {31'd0, (p_cpha ? 1'b0 : exp_bits[0])});
         check("mosi_hold",   {31'd0, mosi_hold},  32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int          ta, tr, ta2, tr2;
      logic        r_sel, r_cpol, r_cpha, r_lsb, r_loop, r_miso;
      logic [1:0]  r_cs;
      logic [15:0] r_data;

      repeat (3) @(negedge clk);
      sel = 1'b0; #1;
      check("rst_a_sclk",  {31'd0, o_sclk},  32'd0);
      check("rst_a_mosi",  {31'd0, o_mosi},  32'd0);
      check("rst_a_cs_n",  {28'd0, o_csn},   32'hF);
      check("rst_a_busy",  {31'd0, o_busy},  32'd0);
      check("rst_a_ready", {31'd0, o_ready}, 32'd0);
      check("rst_a_rxv",   {31'd0, o_rxv},   32'd0);
      check("rst_a_rxd",   {16'd0, o_rxd},   32'd0);
      sel = 1'b1; #1;
      check("rst_b_cs_n",  {28'd0, o_csn},   32'hF);
      check("rst_b_ready", {31'd0, o_ready}, 32'd0);
      check("rst_b_rxd",   {16'd0, o_rxd},   32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready",  {31'd0, o_ready}, 32'd1);

      // mode 0, MSB first, loopback 0xA5
      do_xfer(1'b0, 16'h00A5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 0, ta, tr);
      check("a5_rxv_at_T37", tr - ta, 32'd37);

      // idle sclk follows cpol
      sel = 1'b0; cpol_v = 1'b1;
      @(negedge clk); @(negedge clk);
      check("idle_sclk_cpol1", {31'd0, o_sclk}, 32'd1);

      // mode 3, LSB first, 0x01, miso tied high
      do_xfer(1'b0, 16'h0001, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 0, ta, tr);

      // chip select 2 of 4
      do_xfer(1'b0, 16'h005A, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 0, ta, tr);

      // DATA_W=16, CLK_DIV=1, mode 1, out-of-range select, loopback 0xBEEF
      do_xfer(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 0, ta, tr);
      check("beef_rxv_at_T35", tr - ta, 32'd35);

      // tx_valid held high across two words
      do_xfer(1'b0, 16'h003C, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 0, ta, tr);
      do_xfer(1'b0, 16'h00C3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 0, ta2, tr2);
      check("b2b_accept_gap", ta2 - ta, 32'd39);
      check("b2b_rxv_gap",    tr2 - tr, 32'd39);

      // randomised words, modes, selects and miso sources
      for (int k = 0; k < 12; k++) begin
         r_sel  = 1'($urandom_range(0, 1));
         r_data = 16'($urandom);
         r_cpol = 1'($urandom_range(0, 1));
         r_cpha = 1'($urandom_range(0, 1));
         r_lsb  = 1'($urandom_range(0, 1));
         r_cs   = 2'($urandom_range(0, 3));
         r_loop = ($urandom_range(0, 3) != 0);
         r_miso = 1'($urandom_range(0, 1));
         if (!r_sel) r_data[15:8] = 8'h00;
         do_xfer(r_sel, r_data, r_cpol, r_cpha, r_lsb, r_cs, r_loop, r_miso, 1'b0, 0, ta, tr);
      end

      // reset during XFER at the leading edge of bit 4 (mode 3)
      r_data = 16'($urandom_range(0, 255));
      do_xfer(1'b0, r_data, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 19, ta, tr);

      // after reset, idle sclk tracks cpol going low again
      cpol_v = 1'b0;
      @(negedge clk); @(negedge clk);
      check("idle_sclk_cpol0", {31'd0, o_sclk}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
